// File: rtl/spi_mosi_par.sv
// -----------------------------------------------------------------------------
// spi_mosi_par -- parallel-to-serial SPI master transmitter.
//
// Accepts a DATA_W-bit word on a valid/ready handshake, then plays out one SPI
// frame: chip-select setup, 2*DATA_W serial-clock edges carrying the word, a
// hold period, and a one-cycle done pulse as chip-select is released.
//
// Parameters
//   DATA_W    frame width in bits (2..32)
//   CLK_DIV   sclk half-period in spi_clk cycles (>= 1)
//   MSB_FIRST 1 = MSB shifted first, 0 = LSB first
//   CPOL      idle level of sclk
//   CPHA      0 = sample on leading edge, 1 = sample on trailing edge
//
// Ports
//   spi_clk       in   system clock, rising edge
//   n_reset       in   asynchronous active-low reset
//   tx_data       in   word to transmit
//   tx_valid      in   transmit request
//   tx_ready      out  idle, able to accept a word
//   sclk          out  serial clock
//   spi_cs        out  chip select, active low
//   spi_mosi_out  out  serial data, 0 whenever spi_cs is high
//   done          out  one-cycle pulse at end of frame
//
// Optional receive path (macro SPI_MOSI_RX_EN)
//   spi_miso_in   in   serial data in, sampled on each sample edge
//   rx_data       out  received word, updated in the done cycle
//   rx_valid      out  one-cycle pulse coincident with done
// -----------------------------------------------------------------------------
module spi_mosi_par #(
   parameter int DATA_W    = 8,
   parameter int CLK_DIV   = 2,
   parameter int MSB_FIRST = 1,
   parameter int CPOL      = 0,
   parameter int CPHA      = 0
) (
   input  logic              spi_clk,
   input  logic              n_reset,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              sclk,
   output logic              spi_cs,
   output logic              spi_mosi_out,
`ifdef SPI_MOSI_RX_EN
   input  logic              spi_miso_in,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
`endif
   output logic              done
);

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

   localparam int               DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int               EDGE_W     = $clog2(2 * DATA_W + 1);
   localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
   localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W);
   localparam logic [EDGE_W-1:0] EDGE_PENU = EDGE_W'(2 * DATA_W - 1);
   localparam logic             SCLK_IDLE  = 1'(CPOL);

   state_t              state_q, state_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [EDGE_W-1:0]   edge_q, edge_d;    // sclk edges produced so far
   logic [DATA_W-1:0]   sr_q, sr_d;
   logic                sclk_q, sclk_d;
   logic                mosi_q, mosi_d;
   logic                done_q, done_d;
   logic                tick;              // current half-period expires this cycle
   logic                fire;              // sclk toggles on this edge
   logic                leading;           // the toggle is a leading edge

   // Bit currently presented on the line, and the register after one shift.
   function automatic logic first_bit(input logic [DATA_W-1:0] w);
      return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
   endfunction

   function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
      return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
   endfunction

   assign tick     = (div_q == '0);
   assign fire     = tick && ((state_q == SETUP) ||
                              ((state_q == SHIFT) && (edge_q != EDGE_LAST)));
   assign leading  = ~edge_q[0];

   // ---------------- state register ----------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge spi_clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q <= IDLE;
         div_q   <= '0;
         edge_q  <= '0;
         sr_q    <= '0;
         sclk_q  <= SCLK_IDLE;
         mosi_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         edge_q  <= edge_d;
         sr_q    <= sr_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         done_q  <= done_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and infers a latch.
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (tx_valid) state_d = SETUP;
         SETUP:   if (tick) state_d = SHIFT;
         SHIFT:   if (tick && (edge_q == EDGE_LAST)) state_d = HOLD;
         HOLD:    if (tick) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- datapath / output logic ----------------
   always_comb begin
      div_d  = div_q;
      edge_d = edge_q;
      sr_d   = sr_q;
      sclk_d = sclk_q;
      mosi_d = mosi_q;
      done_d = 1'b0;

      if (state_q == IDLE) begin
         if (tx_valid) begin
            div_d  = DIV_RELOAD;
            edge_d = '0;
            sr_d   = tx_data;
            // CPHA=0 must present the first bit before the first (sampling) edge.
            mosi_d = (CPHA == 0) ? first_bit(tx_data) : 1'b0;
         end
      end else begin
         div_d = tick ? DIV_RELOAD : div_q - DIV_W'(1);
      end

      if (fire) begin
         sclk_d = ~sclk_q;
         edge_d = edge_q + EDGE_W'(1);
         if (leading) begin
            if (CPHA != 0) begin
               mosi_d = first_bit(sr_q);
               sr_d   = shift_out(sr_q);
            end
         end else if ((CPHA == 0) && (edge_q != EDGE_PENU)) begin
            // Advance on every trailing edge except the final one.
            sr_d   = shift_out(sr_q);
            mosi_d = first_bit(shift_out(sr_q));
         end
      end

      if ((state_q == HOLD) && tick) begin
         done_d = 1'b1;
         mosi_d = 1'b0;
      end
   end

   assign tx_ready     = (state_q == IDLE);
   assign spi_cs       = (state_q == IDLE);
   assign sclk         = sclk_q;
   assign spi_mosi_out = mosi_q;
   assign done         = done_q;

`ifdef SPI_MOSI_RX_EN
   logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;

   always_ff @(posedge spi_clk or negedge n_reset) begin
      if (!n_reset) begin
         rx_sr_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         rx_sr_q    <= rx_sr_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   always_comb begin
      rx_sr_d    = rx_sr_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      if ((state_q == IDLE) && tx_valid) begin
         rx_sr_d = '0;
      end
      // Sample edge: leading for CPHA=0, trailing for CPHA=1.
      if (fire && (leading == (CPHA == 0))) begin
         rx_sr_d = (MSB_FIRST != 0) ? {rx_sr_q[DATA_W-2:0], spi_miso_in}
                                    : {spi_miso_in, rx_sr_q[DATA_W-1:1]};
      end
      if ((state_q == HOLD) && tick) begin
         rx_data_d  = rx_sr_q;
         rx_valid_d = 1'b1;
      end
   end

   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
`endif

endmodule
